// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller.
// Freezes the stages up to the deepest stalling stage, inserts a bubble behind
// it, and applies redirect flushes either immediately or, when the flushing
// stage is itself frozen, as soon as the freeze drops below it. A saturating
// stall counter and a consecutive-stall watchdog give hang visibility.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | no flush outstanding
//   ST_PEND | flush requested while stage FLUSH_SRC or deeper was stalled;
//           | waiting for the first cycle it can be applied
module stall_ctrl #(
   parameter int N_STAGE    = 5,
   parameter int FLUSH_SRC  = 2,
   parameter int WDOG_LIMIT = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_STAGE-1:0]   stall_req,
   input  logic                 flush_req,
   output logic [2*N_STAGE-1:0] stall_sign,
   output logic [N_STAGE-1:0]   bubble_sign,
   output logic                 redirect_en,
   output logic [31:0]          stall_cnt,
   output logic                 wdog_err
);

   localparam int               RUN_W   = $clog2(WDOG_LIMIT + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(WDOG_LIMIT);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [31:0]          cnt_q, cnt_d;
   logic [RUN_W-1:0]     run_q, run_d;
   logic                 wdog_q, wdog_d;

   int                   k;
   logic                 any_stall;
   logic                 flush_want;
   logic                 flush_go;
   logic                 sign_any;
   logic [2*N_STAGE-1:0] sign_raw;
   logic [N_STAGE-1:0]   bub_raw;
   logic                 redir_raw;

   // Deepest stage currently requesting a stall.
   always_comb begin
      k = 0;
      for (int i = 0; i < N_STAGE; i++) begin
         if (stall_req[i]) k = i;
      end
   end

   assign any_stall  = |stall_req;
   assign flush_want = flush_req | (state_q == ST_PEND);
   // A flush may go ahead only when nothing at or beyond the flushing stage is frozen;
   // any shallower stall belongs to the wrong path and is dropped.
   assign flush_go   = flush_want & (~any_stall | (k < FLUSH_SRC));

   // Stall/bubble/redirect decode and next flush state.
   always_comb begin
      sign_raw  = '0;
      bub_raw   = '0;
      redir_raw = 1'b0;
      state_d   = ST_IDLE;
      if (flush_go) begin
         redir_raw = 1'b1;
         for (int i = 0; i < FLUSH_SRC; i++) bub_raw[i] = 1'b1;
      end else begin
         if (any_stall) begin
            for (int j = 0; j < 2*N_STAGE; j++) begin
               if (j < 2*k) sign_raw[j] = 1'b1;
            end
            for (int i = 0; i < N_STAGE; i++) begin
               if (i == k) bub_raw[i] = 1'b1;
            end
         end
         if (flush_want) state_d = ST_PEND;
      end
   end

   // Reset gates the strobes combinationally so nothing leaks while rst is low.
   assign stall_sign  = rst ? sign_raw  : '0;
   assign bubble_sign = rst ? bub_raw   : '0;
   assign redirect_en = rst ? redir_raw : 1'b0;
   assign sign_any    = |stall_sign;

   // Saturating total-stall counter, consecutive-stall run counter and sticky watchdog.
   always_comb begin
      cnt_d  = cnt_q;
      run_d  = '0;
      if (sign_any) begin
         if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
         run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
      end
      wdog_d = wdog_q | (run_d == RUN_MAX);
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         run_q   <= '0;
         wdog_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         run_q   <= run_d;
         wdog_q  <= wdog_d;
      end
   end

   assign stall_cnt = cnt_q;
   assign wdog_err  = wdog_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Bench for stall_ctrl with N_STAGE=5, FLUSH_SRC=2, WDOG_LIMIT=4.
module tb_stall_ctrl;

   localparam int NS  = 5;
   localparam int FS  = 2;
   localparam int LIM = 4;

   logic            clk;
   logic            rst;
   logic [NS-1:0]   stall_req;
   logic            flush_req;
   logic [2*NS-1:0] stall_sign;
   logic [NS-1:0]   bubble_sign;
   logic            redirect_en;
   logic [31:0]     stall_cnt;
   logic            wdog_err;

   stall_ctrl #(.N_STAGE(NS), .FLUSH_SRC(FS), .WDOG_LIMIT(LIM)) dut (
      .clk         (clk),
      .rst         (rst),
      .stall_req   (stall_req),
      .flush_req   (flush_req),
      .stall_sign  (stall_sign),
      .bubble_sign (bubble_sign),
      .redirect_en (redirect_en),
      .stall_cnt   (stall_cnt),
      .wdog_err    (wdog_err)
   );

   typedef struct {
      logic [2*NS-1:0] sign;
      logic [NS-1:0]   bub;
      logic            red;
      logic [31:0]     cnt;
      logic            wdog;
   } exp_t;

   exp_t sb[$];

   int errors = 0;
   int checks = 0;

   // reference model state
   logic        m_pend = 1'b0;
   logic [31:0] m_cnt  = '0;
   int          m_run  = 0;
   logic        m_wdog = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: sim time exceeded limit");
      $fatal(1, "timeout");
   end

   // One clock cycle: drive, predict into the scoreboard, compare at negedge, advance.
   task automatic cycle(input string tag, input logic [NS-1:0] sreq, input logic freq,
                        output logic [2*NS-1:0] o_sign, output logic [NS-1:0] o_bub,
                        output logic o_red);
      exp_t e;
      exp_t g;
      int   kk;
      logic fl;
      logic nxt_pend;
      stall_req = sreq;
      flush_req = freq;
      kk = -1;
      for (int i = NS-1; i >= 0; i--) if (sreq[i] && kk < 0) kk = i;
      fl = freq || m_pend;
      if (fl && kk < FS) begin
         e.sign = '0;
         e.bub  = NS'((1 << FS) - 1);
         e.red  = 1'b1;
         nxt_pend = 1'b0;
      end else begin
         e.sign = (kk > 0) ? (2*NS)'((1 << (2*kk)) - 1) : '0;
         e.bub  = (kk >= 0) ? NS'(1 << kk) : '0;
         e.red  = 1'b0;
         nxt_pend = fl;
      end
      e.cnt  = m_cnt;
      e.wdog = m_wdog;
      sb.push_back(e);
      @(negedge clk);
      g = sb.pop_front();
      o_sign = stall_sign;
      o_bub  = bubble_sign;
      o_red  = redirect_en;
      checks++;
      if (stall_sign !== g.sign) begin
         errors++;
         $display("FAIL %s stall_sign: got %b want %b", tag, stall_sign, g.sign);
      end
      checks++;
      if (bubble_sign !== g.bub) begin
         errors++;
         $display("FAIL %s bubble_sign: got %b want %b", tag, bubble_sign, g.bub);
      end
      checks++;
      if (redirect_en !== g.red) begin
         errors++;
         $display("FAIL %s redirect_en: got %b want %b", tag, redirect_en, g.red);
      end
      checks++;
      if (stall_cnt !== g.cnt) begin
         errors++;
         $display("FAIL %s stall_cnt: got %0d want %0d", tag, stall_cnt, g.cnt);
      end
      checks++;
      if (wdog_err !== g.wdog) begin
         errors++;
         $display("FAIL %s wdog_err: got %b want %b", tag, wdog_err, g.wdog);
      end
      if (g.sign != '0) begin
         if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
         if (m_run < LIM) m_run++;
      end else begin
         m_run = 0;
      end
      if (m_run == LIM) m_wdog = 1'b1;
      m_pend = nxt_pend;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_bit(input string tag, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %b want %b", tag, got, want);
      end
   endtask

   // Reset asserted mid-cycle with busy inputs; released before the next edge.
   task automatic test_reset();
      rst       = 1'b0;
      stall_req = 5'b11111;
      flush_req = 1'b1;
      #2;
      checks++;
      if (stall_sign !== '0) begin
         errors++;
         $display("FAIL reset stall_sign: got %b want 0", stall_sign);
      end
      checks++;
      if (bubble_sign !== '0) begin
         errors++;
         $display("FAIL reset bubble_sign: got %b want 0", bubble_sign);
      end
      expect_bit("reset redirect_en", redirect_en, 1'b0);
      checks++;
      if (stall_cnt !== 32'd0) begin
         errors++;
         $display("FAIL reset stall_cnt: got %0d want 0", stall_cnt);
      end
      expect_bit("reset wdog_err", wdog_err, 1'b0);
      @(negedge clk);
      rst       = 1'b1;
      stall_req = '0;
      flush_req = 1'b0;
      m_pend = 1'b0;
      m_cnt  = '0;
      m_run  = 0;
      m_wdog = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_stall();
      logic [2*NS-1:0] s;
      logic [NS-1:0]   b;
      logic            r;
      for (int i = 0; i < 3; i++) begin
         cycle("stall_k3", 5'b01000, 1'b0, s, b, r);
         checks++;
         if (s !== 10'b0000111111 || b !== 5'b01000) begin
            errors++;
            $display("FAIL stall_k3 literal: got %b/%b want 0000111111/01000", s, b);
         end
      end
      checks++;
      if (stall_cnt !== 32'd3) begin
         errors++;
         $display("FAIL stall_cnt_after3: got %0d want 3", stall_cnt);
      end
      cycle("stall_free", 5'b00000, 1'b0, s, b, r);
   endtask

   task automatic test_k0();
      logic [2*NS-1:0] s;
      logic [NS-1:0]   b;
      logic            r;
      cycle("k0", 5'b00001, 1'b0, s, b, r);
      checks++;
      if (s !== '0 || b !== 5'b00001) begin
         errors++;
         $display("FAIL k0 literal: got %b/%b want 0/00001", s, b);
      end
      cycle("k0_flush", 5'b00001, 1'b1, s, b, r);
      cycle("k0_after", 5'b00000, 1'b0, s, b, r);
   endtask

   task automatic test_flush_idle();
      logic [2*NS-1:0] s;
      logic [NS-1:0]   b;
      logic            r;
      cycle("flush_idle", 5'b00000, 1'b1, s, b, r);
      checks++;
      if (b !== 5'b00011 || r !== 1'b1 || s !== '0) begin
         errors++;
         $display("FAIL flush_idle literal: got %b/%b/%b want 0/00011/1", s, b, r);
      end
      cycle("flush_idle_next", 5'b00000, 1'b0, s, b, r);
      expect_bit("flush_idle_once", r, 1'b0);
   endtask

   task automatic test_flush_deferred();
      logic [2*NS-1:0] s;
      logic [NS-1:0]   b;
      logic            r;
      int              reds = 0;
      cycle("defer_0", 5'b01000, 1'b1, s, b, r);
      reds += int'(r);
      cycle("defer_1", 5'b01000, 1'b1, s, b, r);
      reds += int'(r);
      cycle("defer_2", 5'b01000, 1'b0, s, b, r);
      reds += int'(r);
      expect_bit("defer_no_redirect_in_stall", reds != 0, 1'b0);
      cycle("defer_apply", 5'b00000, 1'b0, s, b, r);
      checks++;
      if (b !== 5'b00011 || r !== 1'b1) begin
         errors++;
         $display("FAIL defer_apply literal: got %b/%b want 00011/1", b, r);
      end
      cycle("defer_after", 5'b00000, 1'b0, s, b, r);
      expect_bit("defer_once", r, 1'b0);
   endtask

   task automatic test_low_stall_flush();
      logic [2*NS-1:0] s;
      logic [NS-1:0]   b;
      logic            r;
      cycle("low_stall_flush", 5'b00010, 1'b1, s, b, r);
      checks++;
      if (s !== '0 || b !== 5'b00011 || r !== 1'b1) begin
         errors++;
         $display("FAIL low_stall_flush literal: got %b/%b/%b want 0/00011/1", s, b, r);
      end
      cycle("low_stall_after", 5'b00010, 1'b0, s, b, r);
   endtask

   task automatic test_merge_apply();
      logic [2*NS-1:0] s;
      logic [NS-1:0]   b;
      logic            r;
      cycle("merge_defer", 5'b00100, 1'b1, s, b, r);
      cycle("merge_apply", 5'b00000, 1'b1, s, b, r);
      expect_bit("merge_apply_red", r, 1'b1);
      cycle("merge_after", 5'b00000, 1'b0, s, b, r);
      expect_bit("merge_once", r, 1'b0);
   endtask

   task automatic test_wdog();
      logic [2*NS-1:0] s;
      logic [NS-1:0]   b;
      logic            r;
      test_reset();
      for (int i = 1; i <= 6; i++) begin
         cycle("wdog_stall", 5'b10000, 1'b0, s, b, r);
         expect_bit($sformatf("wdog_after_%0d", i), wdog_err, (i >= 4));
      end
      cycle("wdog_rel0", 5'b00000, 1'b0, s, b, r);
      cycle("wdog_rel1", 5'b00000, 1'b0, s, b, r);
      expect_bit("wdog_sticky", wdog_err, 1'b1);
      test_reset();
      expect_bit("wdog_cleared", wdog_err, 1'b0);
   endtask

   task automatic test_reset_pending();
      logic [2*NS-1:0] s;
      logic [NS-1:0]   b;
      logic            r;
      int              reds = 0;
      cycle("rstpend_defer", 5'b01000, 1'b1, s, b, r);
      test_reset();
      for (int i = 0; i < 3; i++) begin
         cycle("rstpend_free", 5'b00000, 1'b0, s, b, r);
         reds += int'(r);
      end
      expect_bit("rstpend_no_redirect", reds != 0, 1'b0);
   endtask

   task automatic test_random();
      logic [2*NS-1:0] s;
      logic [NS-1:0]   b;
      logic            r;
      logic [NS-1:0]   sr;
      for (int i = 0; i < 60; i++) begin
         sr = ($urandom_range(0, 2) == 0) ? '0 : NS'($urandom_range(0, 31));
         cycle("random", sr, ($urandom_range(0, 3) == 0), s, b, r);
      end
   endtask

   initial begin
      rst       = 1'b0;
      stall_req = '0;
      flush_req = 1'b0;
      test_reset();
      test_stall();
      test_k0();
      test_flush_idle();
      test_flush_deferred();
      test_low_stall_flush();
      test_merge_apply();
      test_wdog();
      test_reset_pending();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
